// File: rtl/hist_acq_controller.sv
// Pulse-height histogram run sequencer: clears the bin RAM, bins qualified ADC samples
// for a timed window, then streams every bin out over AXI-Stream.
module hist_acq_controller #(
    parameter int ADC_WIDTH       = 12,
    parameter int HIST_ADDR_WIDTH = 10,
    parameter int HIST_DATA_WIDTH = 32,
    parameter int TIMER_WIDTH     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [TIMER_WIDTH-1:0] run_cycles,
    input  logic [ADC_WIDTH-1:0]   threshold_value,
    input  logic [ADC_WIDTH-1:0]   adc_data,
    input  logic                   adc_valid,
    output logic [31:0]            m_axis_tdata,
    output logic                   m_axis_tvalid,
    output logic                   m_axis_tlast,
    input  logic                   m_axis_tready,
    output logic                   busy,
    output logic                   done,
    output logic [31:0]            event_count,
    output logic [2:0]             state_o
);

    localparam int NBINS = 1 << HIST_ADDR_WIDTH;
    localparam logic [HIST_ADDR_WIDTH-1:0] LAST_ADDR = {HIST_ADDR_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ACQUIRE = 3'd2,
        S_DRAIN   = 3'd3,
        S_READOUT = 3'd4
    } state_t;

    function automatic logic [HIST_DATA_WIDTH-1:0] bin_sat_inc(input logic [HIST_DATA_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [31:0] evt_sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    logic [HIST_DATA_WIDTH-1:0] mem [NBINS];

    state_t                     state_q, state_d;
    logic [HIST_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [TIMER_WIDTH-1:0]     timer_q, timer_d;
    logic [TIMER_WIDTH-1:0]     run_q, run_d;
    logic [ADC_WIDTH-1:0]       thr_q, thr_d;
    logic [31:0]                evt_q, evt_d;
    logic                       upd_vld_p0_q, upd_vld_p0_d;
    logic [HIST_ADDR_WIDTH-1:0] upd_addr_p0_q, upd_addr_p0_d;
    logic                       wr_vld_p1_q, wr_vld_p1_d;
    logic [HIST_ADDR_WIDTH-1:0] wr_addr_p1_q, wr_addr_p1_d;
    logic [HIST_DATA_WIDTH-1:0] wr_data_p1_q, wr_data_p1_d;
    logic [HIST_DATA_WIDTH-1:0] rd_q;
    logic                       tvalid_q, tvalid_d;
    logic                       tlast_q, tlast_d;
    logic                       done_q, done_d;

    logic                       qualify;
    logic [HIST_ADDR_WIDTH-1:0] bin;
    logic [HIST_DATA_WIDTH-1:0] upd_old, upd_new;
    logic                       we, re;
    logic [HIST_ADDR_WIDTH-1:0] waddr, raddr;
    logic [HIST_DATA_WIDTH-1:0] wdata;

    assign bin     = adc_data[ADC_WIDTH-1 -: HIST_ADDR_WIDTH];
    assign qualify = (state_q == S_ACQUIRE) && adc_valid && (adc_data > thr_q) && !abort;
    // The RAM read for this update was issued while the previous write was still in flight.
    assign upd_old = (wr_vld_p1_q && (wr_addr_p1_q == upd_addr_p0_q)) ? wr_data_p1_q : rd_q;
    assign upd_new = bin_sat_inc(upd_old);

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        timer_d       = timer_q;
        run_d         = run_q;
        thr_d         = thr_q;
        evt_d         = evt_q;
        upd_vld_p0_d  = 1'b0;
        upd_addr_p0_d = bin;
        wr_vld_p1_d   = 1'b0;
        wr_addr_p1_d  = wr_addr_p1_q;
        wr_data_p1_d  = wr_data_p1_q;
        tvalid_d      = tvalid_q;
        tlast_d       = tlast_q;
        done_d        = 1'b0;
        we            = 1'b0;
        waddr         = addr_q;
        wdata         = '0;
        re            = 1'b0;
        raddr         = addr_q;

        // p0 -> p1: write back the incremented bin
        if (upd_vld_p0_q) begin
            we           = 1'b1;
            waddr        = upd_addr_p0_q;
            wdata        = upd_new;
            wr_vld_p1_d  = 1'b1;
            wr_addr_p1_d = upd_addr_p0_q;
            wr_data_p1_d = upd_new;
        end
        if (qualify) begin
            upd_vld_p0_d = 1'b1;
            re           = 1'b1;
            raddr        = bin;
            evt_d        = evt_sat_inc(evt_q);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CLEAR;
                    run_d   = run_cycles;
                    thr_d   = threshold_value;
                    evt_d   = '0;
                    addr_d  = '0;
                end
            end
            S_CLEAR: begin
                we     = 1'b1;
                waddr  = addr_q;
                wdata  = '0;
                addr_d = addr_q + 1'b1;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    timer_d = run_q - 1'b1;
                    state_d = (run_q == '0) ? S_DRAIN : S_ACQUIRE;
                end
            end
            S_ACQUIRE: begin
                timer_d = timer_q - 1'b1;
                if (timer_q == '0) begin
                    state_d = S_DRAIN;
                    addr_d  = '0;
                end
            end
            S_DRAIN: begin
                addr_d = addr_q + 1'b1;
                if (addr_q[0]) begin
                    state_d = S_READOUT;
                    addr_d  = '0;
                end
            end
            S_READOUT: begin
                if (tvalid_q && m_axis_tready && tlast_q) begin
                    state_d  = S_IDLE;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    done_d   = 1'b1;
                end else if (!tvalid_q || m_axis_tready) begin
                    re       = 1'b1;
                    raddr    = addr_q;
                    tvalid_d = 1'b1;
                    tlast_d  = (addr_q == LAST_ADDR);
                    addr_d   = addr_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d      = S_IDLE;
            evt_d        = evt_q;
            tvalid_d     = 1'b0;
            tlast_d      = 1'b0;
            done_d       = 1'b0;
            upd_vld_p0_d = 1'b0;
            wr_vld_p1_d  = 1'b0;
            we           = 1'b0;
            re           = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            timer_q      <= '0;
            evt_q        <= '0;
            upd_vld_p0_q <= 1'b0;
            wr_vld_p1_q  <= 1'b0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            timer_q      <= timer_d;
            evt_q        <= evt_d;
            upd_vld_p0_q <= upd_vld_p0_d;
            wr_vld_p1_q  <= wr_vld_p1_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            done_q       <= done_d;
        end
    end

    always_ff @(posedge clk) begin
        run_q         <= run_d;
        thr_q         <= thr_d;
        upd_addr_p0_q <= upd_addr_p0_d;
        wr_addr_p1_q  <= wr_addr_p1_d;
        wr_data_p1_q  <= wr_data_p1_d;
        if (re) rd_q <= mem[raddr];
        if (we) mem[waddr] <= wdata;
    end

    assign m_axis_tdata  = tvalid_q ? 32'(rd_q) : 32'd0;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign busy          = (state_q != S_IDLE);
    assign done          = done_q;
    assign event_count   = evt_q;
    assign state_o       = state_q;

endmodule
